median_scan_ctrl: RTL and testbench
===================================

MEDIAN_SCAN_CTRL -- requirements
Module: median_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default 256, image width in pixels; legal range 3..1024.
REQ-002 Parameter IMG_H, default 256, image height in lines; legal range 3..1024.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  frame start request; sampled only in IDLE.
REQ-006 abort_i  input  1  synchronous frame abort.
REQ-007 pix_valid_i  input  1  upstream pixel present.
REQ-008 pix_ready_o  output  1  block accepts pixel this cycle.
REQ-009 out_ready_i  input  1  downstream filter can take a window.
REQ-010 col_o  output  10  column of the pixel in the current handshake.
REQ-011 row_o  output  10  row of the pixel in the current handshake.
REQ-012 lb_wr_en_o  output  1  line-buffer write strobe, equal to the accept condition.
REQ-013 lb_sel_o  output  2  line buffer being written, cycling 0,1,2.
REQ-014 window_valid_o  output  1  accepted pixel completes a full 3x3 window.
REQ-015 busy_o  output  1  frame in progress.
REQ-016 done_o  output  1  one-cycle end-of-frame pulse.

Function
REQ-017 FSM states: IDLE, RUN, DONE; encoding is internal.
- IDLE->RUN on start_i=1.
- RUN->DONE on acceptance of pixel (IMG_H-1, IMG_W-1).
- DONE->IDLE unconditionally after one cycle.
REQ-018 Accept condition: state==RUN && pix_valid_i && out_ready_i; pix_ready_o = state==RUN && out_ready_i, independent of pix_valid_i.
REQ-019 On accept with col<IMG_W-1: col+1 on the next edge.
REQ-020 On accept with col==IMG_W-1: col clears to 0, row+1, lb_sel advances 0->1->2->0.
REQ-021 On the final-pixel accept: col, row and lb_sel all clear to 0.
REQ-022 Without an accept (stall or bubble), col, row and lb_sel hold.
REQ-023 col_o and row_o show the counter values combinationally; they are valid whenever pix_ready_o=1.
REQ-024 window_valid_o = accept && row>=2 && col>=2; it is combinational; window centre is (row-1, col-1).
REQ-025 busy_o=1 exactly in RUN; done_o=1 exactly in DONE.
REQ-026 start_i is ignored in RUN and DONE; start_i in DONE does not start a new frame.
REQ-027 abort_i in RUN forces IDLE and clears col, row and lb_sel on the next edge, with no done_o pulse.
- abort_i overrides a simultaneous accept, including the final pixel.
- abort_i has no effect in IDLE or DONE.
REQ-028 Counter widths are 10 bits; with legal parameters no counter wraps.

Reset
REQ-029 RST=0 asynchronously forces IDLE, col=0, row=0 and lb_sel=0.
- Outputs after reset: pix_ready_o=0, lb_wr_en_o=0, window_valid_o=0, busy_o=0, done_o=0, col_o=0, row_o=0, lb_sel_o=0.
REQ-030 Reset mid-frame discards progress; a new start_i is required after release.

Structure
REQ-031 The shared package holds the FSM state constants and the 10-bit coordinate width constant.
REQ-032 The column and row counters are two instances of counter_10_bit.
- Column counter: increment_i=accept, clear_i = accept && col==IMG_W-1, or abort.
- Row counter: increment_i = accept && col==IMG_W-1, clear_i = final-pixel accept, or abort.
- clear_i dominates increment_i.
REQ-033 lb_sel, the FSM and the handshake logic are local.

Verification (IMG_W=4, IMG_H=3)
REQ-034 Reset, then start_i pulse with pix_valid_i=out_ready_i=1 for 12 cycles.
- Expect col_o 0,1,2,3 repeating and row_o 0,0,0,0,1,...,2.
- Expect window_valid_o only at (2,2) and (2,3).
- Expect done_o once, one cycle after the 12th accept; busy_o=0 afterwards.
REQ-035 At (1,1), drop out_ready_i for 3 cycles.
- Expect pix_ready_o=0, lb_wr_en_o=0, col and row held at (1,1); the scan resumes at (1,1).
REQ-036 At (0,1), drop pix_valid_i for 2 cycles.
- Expect pix_ready_o=1, no increment, lb_wr_en_o=0.
REQ-037 Check lb_sel_o across the frame.
- Expect 0 for row 0, 1 for row 1, 2 for row 2, and 0 after the frame.
- A second frame started at IMG_H=4 shows lb_sel_o=0 on row 3.
REQ-038 abort_i together with the accept at (2,3).
- Expect IDLE next cycle, col=row=0, no done_o.
REQ-039 RST=0 at (1,2); expect all outputs at their reset values immediately, before the next CLK edge.
REQ-040 start_i asserted during DONE; expect no new frame to start.

Source files
------------

// File: rtl/median_scan_ctrl_pkg.sv
// Shared types for the 3x3 median-filter scan controller: FSM states,
// coordinate width and the counter control bundle.
package median_scan_ctrl_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  // Per-counter control; clr has priority over inc inside the counter.
  typedef struct packed {
    logic inc;
    logic clr;
  } cnt_ctl_t;

  function automatic logic [1:0] next_lb_sel(input logic [1:0] sel);
    return (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  endfunction

endpackage

// File: rtl/median_scan_ctrl_if.sv
// Handshake and status bundle between the pixel source/filter and the scan controller.
interface median_scan_ctrl_if;
  import median_scan_ctrl_pkg::*;

  logic       start_i;
  logic       abort_i;
  logic       pix_valid_i;
  logic       pix_ready_o;
  logic       out_ready_i;
  coord_t     col_o;
  coord_t     row_o;
  logic       lb_wr_en_o;
  logic [1:0] lb_sel_o;
  logic       window_valid_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i, abort_i, pix_valid_i, out_ready_i,
    input  pix_ready_o, col_o, row_o, lb_wr_en_o, lb_sel_o,
           window_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, pix_valid_i, out_ready_i,
    output pix_ready_o, col_o, row_o, lb_wr_en_o, lb_sel_o,
           window_valid_o, busy_o, done_o
  );

endinterface

// File: rtl/median_scan_ctrl_counter.sv
// 10-bit up counter with synchronous clear (dominant) and increment.
module counter_10_bit
  import median_scan_ctrl_pkg::*;
(
  input  logic   gclk,
  input  logic   grst_n,
  input  logic   increment_i,
  input  logic   clear_i,
  output coord_t count_o
);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)          count_o <= '0;
    else if (clear_i)     count_o <= '0;
    else if (increment_i) count_o <= count_o + coord_t'(1);
  end

endmodule

// File: rtl/median_scan_ctrl.sv
// Raster-scan controller for a 3x3 window filter: tracks pixel coordinates,
// rotates three line buffers and flags pixels that complete a full window.
module median_scan_ctrl
  import median_scan_ctrl_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic CLK,
  input  logic RST,
  median_scan_ctrl_if.slave bus
);

  localparam coord_t COL_LAST = coord_t'(IMG_W - 1);
  localparam coord_t ROW_LAST = coord_t'(IMG_H - 1);
  localparam coord_t WIN_MIN  = coord_t'(2);

  scan_state_e state, state_nxt;
  coord_t      col, row;
  logic [1:0]  lb_sel;

  logic     run, accept, line_end, frame_end, abort_run;
  cnt_ctl_t col_ctl, row_ctl;

  // ---------------- handshake ----------------
  assign run       = (state == ST_RUN);
  assign accept    = run && bus.pix_valid_i && bus.out_ready_i;
  assign line_end  = accept && (col == COL_LAST);
  assign frame_end = line_end && (row == ROW_LAST);
  assign abort_run = run && bus.abort_i;

  // ---------------- coordinate counters ----------------
  always_comb begin
    col_ctl.inc = accept;
    col_ctl.clr = line_end || abort_run;
    row_ctl.inc = line_end;
    row_ctl.clr = frame_end || abort_run;
  end

  counter_10_bit u_col_cnt (
    .gclk        (CLK),
    .grst_n      (RST),
    .increment_i (col_ctl.inc),
    .clear_i     (col_ctl.clr),
    .count_o     (col)
  );

  counter_10_bit u_row_cnt (
    .gclk        (CLK),
    .grst_n      (RST),
    .increment_i (row_ctl.inc),
    .clear_i     (row_ctl.clr),
    .count_o     (row)
  );

  // Line-buffer rotation follows row mod 3; the frame end returns it to 0
  // so the next frame always starts writing buffer 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                        lb_sel <= 2'd0;
    else if (abort_run || frame_end) lb_sel <= 2'd0;
    else if (line_end)               lb_sel <= next_lb_sel(lb_sel);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Abort is checked before the final-pixel accept so it wins the race.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start_i) state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.abort_i)    state_nxt = ST_IDLE;
        else if (frame_end) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  assign bus.pix_ready_o    = run && bus.out_ready_i;
  assign bus.lb_wr_en_o     = accept;
  assign bus.col_o          = col;
  assign bus.row_o          = row;
  assign bus.lb_sel_o       = lb_sel;
  assign bus.window_valid_o = accept && (row >= WIN_MIN) && (col >= WIN_MIN);
  assign bus.busy_o         = run;
  assign bus.done_o         = (state == ST_DONE);

endmodule

// File: tb/tb_median_scan_ctrl.sv
// Directed + randomized bench: two instances (4x3 and 4x4) driven in lockstep
// and compared each cycle against a pixel-index reference model.
module tb_median_scan_ctrl;

  localparam int W = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  median_scan_ctrl_if b0 ();
  median_scan_ctrl_if b1 ();

  median_scan_ctrl #(.IMG_W(W), .IMG_H(3)) dut0 (.CLK(CLK), .RST(RST), .bus(b0));
  median_scan_ctrl #(.IMG_W(W), .IMG_H(4)) dut1 (.CLK(CLK), .RST(RST), .bus(b1));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 scanning, 2 end-of-frame; idx = pixels accepted.
  int m_mode [2];
  int m_idx  [2];
  int m_h    [2] = '{3, 4};

  logic cur_s, cur_a, cur_pv, cur_or;

  int done_cnt0, win_cnt0;

  task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0;
      m_idx[d]  = 0;
    end
  endtask

  task automatic check_dut(input int d, input logic pr, input logic wr, input logic wv,
                           input logic busy, input logic done, input logic [9:0] col,
                           input logic [9:0] row, input logic [1:0] lb);
    logic run, acc;
    int   c, r;
    run = (m_mode[d] == 1);
    acc = run && cur_pv && cur_or;
    c   = m_idx[d] % W;
    r   = m_idx[d] / W;
    chk("pix_ready", d, 16'(pr), 16'(run && cur_or));
    chk("lb_wr_en",  d, 16'(wr), 16'(acc));
    chk("win_valid", d, 16'(wv), 16'(acc && r >= 2 && c >= 2));
    chk("busy",      d, 16'(busy), 16'(run));
    chk("done",      d, 16'(done), 16'(m_mode[d] == 2));
    chk("col",       d, 16'(col), 16'(c));
    chk("row",       d, 16'(row), 16'(r));
    chk("lb_sel",    d, 16'(lb),  16'(r % 3));
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      case (m_mode[d])
        0: if (cur_s) m_mode[d] = 1;
        1: begin
          if (cur_a) begin
            m_mode[d] = 0;
            m_idx[d]  = 0;
          end else if (cur_pv && cur_or) begin
            if (m_idx[d] == W * m_h[d] - 1) begin
              m_mode[d] = 2;
              m_idx[d]  = 0;
            end else m_idx[d]++;
          end
        end
        default: m_mode[d] = 0;
      endcase
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic tick(input logic s, input logic a, input logic pv, input logic orr);
    cur_s = s; cur_a = a; cur_pv = pv; cur_or = orr;
    b0.start_i = s; b0.abort_i = a; b0.pix_valid_i = pv; b0.out_ready_i = orr;
    b1.start_i = s; b1.abort_i = a; b1.pix_valid_i = pv; b1.out_ready_i = orr;
    @(negedge CLK);
    check_dut(0, b0.pix_ready_o, b0.lb_wr_en_o, b0.window_valid_o, b0.busy_o, b0.done_o,
              b0.col_o, b0.row_o, b0.lb_sel_o);
    check_dut(1, b1.pix_ready_o, b1.lb_wr_en_o, b1.window_valid_o, b1.busy_o, b1.done_o,
              b1.col_o, b1.row_o, b1.lb_sel_o);
    if (b0.done_o)         done_cnt0++;
    if (b0.window_valid_o) win_cnt0++;
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 0, 16'(b0.pix_ready_o), 16'd0);
    chk({tag, "_wr"},    0, 16'(b0.lb_wr_en_o), 16'd0);
    chk({tag, "_wv"},    0, 16'(b0.window_valid_o), 16'd0);
    chk({tag, "_busy"},  0, 16'(b0.busy_o), 16'd0);
    chk({tag, "_done"},  0, 16'(b0.done_o), 16'd0);
    chk({tag, "_col"},   0, 16'(b0.col_o), 16'd0);
    chk({tag, "_row"},   0, 16'(b0.row_o), 16'd0);
    chk({tag, "_lb"},    0, 16'(b0.lb_sel_o), 16'd0);
    chk({tag, "_busy"},  1, 16'(b1.busy_o), 16'd0);
    chk({tag, "_col"},   1, 16'(b1.col_o), 16'd0);
    chk({tag, "_row"},   1, 16'(b1.row_o), 16'd0);
    chk({tag, "_ready"}, 1, 16'(b1.pix_ready_o), 16'd0);
  endtask

  initial begin
    RST = 1'b0;
    cur_s = 0; cur_a = 0; cur_pv = 0; cur_or = 0;
    b0.start_i = 0; b0.abort_i = 0; b0.pix_valid_i = 0; b0.out_ready_i = 0;
    b1.start_i = 0; b1.abort_i = 0; b1.pix_valid_i = 0; b1.out_ready_i = 0;
    model_reset();
    done_cnt0 = 0; win_cnt0 = 0;
    #2;
    check_reset_vals("por");
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Frame 1: full-speed scan; start is re-asserted while dut0 sits in DONE.
    tick(1, 0, 1, 1);
    for (int i = 0; i < 12; i++) tick(0, 0, 1, 1);
    tick(1, 0, 1, 1);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 1);
    chk("done_pulses", 0, 16'(done_cnt0), 16'd1);
    chk("window_count", 0, 16'(win_cnt0), 16'd2);
    chk("idle_after", 0, 16'(b0.busy_o), 16'd0);
    chk("idle_after", 1, 16'(b1.busy_o), 16'd0);

    // Frame 2: bubble at (0,1), downstream stall at (1,1).
    tick(1, 0, 0, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 1);
    chk("at_1_1_col", 0, 16'(b0.col_o), 16'd1);
    chk("at_1_1_row", 0, 16'(b0.row_o), 16'd1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
    for (int i = 0; i < 12; i++) tick(0, 0, 1, 1);

    // Frame 3: abort coincides with the final-pixel accept of dut0.
    tick(1, 0, 1, 1);
    for (int i = 0; i < 11; i++) tick(0, 0, 1, 1);
    done_cnt0 = 0;
    tick(0, 1, 1, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    chk("abort_no_done", 0, 16'(done_cnt0), 16'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(3) == 0), ($urandom_range(39) == 0),
           ($urandom_range(3) != 0), ($urandom_range(4) != 0));
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);

    // Reset arriving mid-frame at (1,2).
    tick(1, 0, 1, 1);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 1);
    chk("pre_rst_col", 0, 16'(b0.col_o), 16'd2);
    chk("pre_rst_row", 0, 16'(b0.row_o), 16'd1);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    check_reset_vals("async_rst");
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    tick(1, 0, 1, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
